hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for load-use stalls, branch
// redirect flushes and data-memory freezes. The outputs are combinational
// from the inputs and the current state.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
// Otherwise no counter flops exist and the counter outputs read zero.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead_EX,
    input  logic [4:0]  rt_EX,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        useRt_ID,
    input  logic        redirect_EX,
    input  logic        dmem_busy,
    input  logic        perf_clr,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        idex_hold,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] freeze_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FREEZE     = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic load_use_c;
    logic stall_evt_c;
    logic flush_evt_c;
    logic freeze_evt_c;

    // Load-use detection: a load in EX writes a register that the ID instruction reads
    always_comb begin
        load_use_c = memRead_EX && (rt_EX != REG_W'(0)) &&
                     ((rt_EX == rs_ID) || (useRt_ID && (rt_EX == rt_ID)));
    end

    // State register; reset drops any owed flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline controls: a freeze wins over a redirect, and a redirect wins over a load-use stall
    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_hold    = 1'b0;
        stall_evt_c  = 1'b0;
        flush_evt_c  = 1'b0;
        freeze_evt_c = 1'b0;

        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = RUN;
        end else if (dmem_busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            freeze_evt_c = 1'b1;
            state_d      = (redirect_EX || (state_q == FLUSH_PEND)) ? FLUSH_PEND : FREEZE;
        end else if (redirect_EX || (state_q == FLUSH_PEND)) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_evt_c = 1'b1;
            state_d     = RUN;
        end else if (load_use_c) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_evt_c = 1'b1;
            state_d     = RUN;
        end else begin
            state_d = RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Counter updates: a clear request wins over any increment
    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q,  stall_evt_c);
        flush_cnt_d  = sat_inc(flush_cnt_q,  flush_evt_c);
        freeze_cnt_d = sat_inc(freeze_cnt_q, freeze_evt_c);
        if (perf_clr) begin
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
            freeze_cnt_d = '0;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = ^{perf_clr, stall_evt_c, flush_evt_c, freeze_evt_c};

    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif

endmodule
